// File: rtl/aemb2_wbarb.sv
// aemb2_wbarb: shares one Wishbone slave (XWB) between the I-cache refill port and the data port.
// One registered transaction in flight plus a turnaround cycle; define AEMB2_WBARB_RR_EN for round-robin.
module aemb2_wbarb #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int TOUT = 255
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_i,

    input  logic          iwb_stb_i,
    input  logic [AW-1:0] iwb_adr_i,
    output logic [DW-1:0] iwb_dat_o,
    output logic          iwb_ack_o,

    input  logic          dwb_stb_i,
    input  logic          dwb_wre_i,
    input  logic [3:0]    dwb_sel_i,
    input  logic [AW-1:0] dwb_adr_i,
    input  logic [DW-1:0] dwb_dat_i,
    output logic [DW-1:0] dwb_dat_o,
    output logic          dwb_ack_o,

    output logic          xwb_cyc_o,
    output logic          xwb_stb_o,
    output logic          xwb_wre_o,
    output logic [3:0]    xwb_sel_o,
    output logic [AW-1:0] xwb_adr_o,
    output logic [DW-1:0] xwb_dat_o,
    input  logic [DW-1:0] xwb_dat_i,
    input  logic          xwb_ack_i,

    output logic          bus_err_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Last counter value before a BUSY state is forced to terminate.
    localparam logic [7:0] TOUT_LAST = 8'(TOUT - 1);
    localparam bit         TOUT_EN   = (TOUT != 0);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] tout_cnt;
    logic       req_any;
    logic       grant_d;
    logic       busy;
    logic       tout_hit;
    logic       term;

    assign req_any  = iwb_stb_i | dwb_stb_i;
    assign busy     = (state == BUSY_I) || (state == BUSY_D);
    assign tout_hit = TOUT_EN && (tout_cnt == TOUT_LAST);
    // An ack arriving on the timeout cycle still terminates normally with real data.
    assign term     = busy && (xwb_ack_i || tout_hit);

    // Cycle and strobe are the same signal on a non-pipelined bus.
    assign xwb_cyc_o = xwb_stb_o;

`ifdef AEMB2_WBARB_RR_EN
    // last_d = 1 when the previous grant went to the data port.
    logic last_d;

    assign grant_d = dwb_stb_i && (!iwb_stb_i || !last_d);

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            last_d <= 1'b0;
        end else if (state == IDLE && req_any) begin
            last_d <= grant_d;
        end
    end
`else
    assign grant_d = dwb_stb_i;
`endif

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: next_state gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req_any) begin
                    state_nxt = grant_d ? BUSY_D : BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (term) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments only; acks and bus_err default low
    // each cycle so they can only ever be single-cycle pulses.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            xwb_stb_o <= 1'b0;
            xwb_wre_o <= 1'b0;
            xwb_sel_o <= '0;
            xwb_adr_o <= '0;
            xwb_dat_o <= '0;
            iwb_dat_o <= '0;
            iwb_ack_o <= 1'b0;
            dwb_dat_o <= '0;
            dwb_ack_o <= 1'b0;
            bus_err_o <= 1'b0;
            tout_cnt  <= '0;
        end else begin
            iwb_ack_o <= 1'b0;
            dwb_ack_o <= 1'b0;
            bus_err_o <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (req_any) begin
                        xwb_stb_o <= 1'b1;
                        tout_cnt  <= '0;
                        if (grant_d) begin
                            xwb_wre_o <= dwb_wre_i;
                            xwb_sel_o <= dwb_sel_i;
                            xwb_adr_o <= dwb_adr_i;
                            xwb_dat_o <= dwb_dat_i;
                        end else begin
                            xwb_wre_o <= 1'b0;
                            xwb_sel_o <= 4'hF;
                            xwb_adr_o <= iwb_adr_i;
                            xwb_dat_o <= '0;
                        end
                    end
                end

                BUSY_I, BUSY_D: begin
                    if (term) begin
                        xwb_stb_o <= 1'b0;
                        xwb_wre_o <= 1'b0;
                        xwb_sel_o <= '0;
                        xwb_adr_o <= '0;
                        xwb_dat_o <= '0;
                        bus_err_o <= !xwb_ack_i;
                        if (state == BUSY_I) begin
                            iwb_ack_o <= 1'b1;
                            iwb_dat_o <= xwb_ack_i ? xwb_dat_i : '0;
                        end else begin
                            dwb_ack_o <= 1'b1;
                            dwb_dat_o <= xwb_ack_i ? xwb_dat_i : '0;
                        end
                    end else begin
                        tout_cnt <= tout_cnt + 8'd1;
                    end
                end

                default: begin
                end
            endcase
        end
    end

    ack_onehot: assert property (@(posedge sys_clk_i) !(iwb_ack_o && dwb_ack_o));
    err_with_ack: assert property (@(posedge sys_clk_i) bus_err_o |-> (iwb_ack_o || dwb_ack_o));

endmodule

// File: tb/tb_aemb2_wbarb.sv
// Testbench for aemb2_wbarb: masters issue request batches, a reference model predicts grant order
// and responses into a scoreboard queue, and a monitor checks every ack against it.
module tb_aemb2_wbarb;

    localparam int TOUT = 8;

    typedef struct {
        logic [31:0] adr;
        logic        wre;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          wait_n;
    } req_t;

    typedef struct {
        bit          is_d;
        logic [31:0] adr;
        logic        wre;
        logic [3:0]  sel;
        logic [31:0] wdat;
        logic [31:0] rdat;
        bit          err;
        int          lat;
        int          wait_n;
    } exp_t;

    logic        sys_clk_i = 1'b0;
    logic        sys_rst_i;
    logic        iwb_stb_i;
    logic [31:0] iwb_adr_i;
    logic [31:0] iwb_dat_o;
    logic        iwb_ack_o;
    logic        dwb_stb_i;
    logic        dwb_wre_i;
    logic [3:0]  dwb_sel_i;
    logic [31:0] dwb_adr_i;
    logic [31:0] dwb_dat_i;
    logic [31:0] dwb_dat_o;
    logic        dwb_ack_o;
    logic        xwb_cyc_o;
    logic        xwb_stb_o;
    logic        xwb_wre_o;
    logic [3:0]  xwb_sel_o;
    logic [31:0] xwb_adr_o;
    logic [31:0] xwb_dat_o;
    logic [31:0] xwb_dat_i;
    logic        xwb_ack_i;
    logic        bus_err_o;

    aemb2_wbarb #(.AW(32), .DW(32), .TOUT(TOUT)) dut (
        .sys_clk_i(sys_clk_i), .sys_rst_i(sys_rst_i),
        .iwb_stb_i(iwb_stb_i), .iwb_adr_i(iwb_adr_i), .iwb_dat_o(iwb_dat_o), .iwb_ack_o(iwb_ack_o),
        .dwb_stb_i(dwb_stb_i), .dwb_wre_i(dwb_wre_i), .dwb_sel_i(dwb_sel_i), .dwb_adr_i(dwb_adr_i),
        .dwb_dat_i(dwb_dat_i), .dwb_dat_o(dwb_dat_o), .dwb_ack_o(dwb_ack_o),
        .xwb_cyc_o(xwb_cyc_o), .xwb_stb_o(xwb_stb_o), .xwb_wre_o(xwb_wre_o), .xwb_sel_o(xwb_sel_o),
        .xwb_adr_o(xwb_adr_o), .xwb_dat_o(xwb_dat_o), .xwb_dat_i(xwb_dat_i), .xwb_ack_i(xwb_ack_i),
        .bus_err_o(bus_err_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    req_t i_reqq[$];
    req_t d_reqq[$];
    req_t bi_q[$];
    req_t bd_q[$];
    bit   i_active = 0, d_active = 0;
    bit   i_ack_seen = 0, d_ack_seen = 0;
    bit   m_last_d = 0;
    logic [31:0] m_idat = '0;
    logic [31:0] m_ddat = '0;
    int   cyc = 0;
    int   rise_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic finish_sum();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    function automatic logic [31:0] slave_rd(input logic [31:0] adr);
        if (adr == 32'h0000_0100) return 32'hDEAD_BEEF;
        return {adr[15:0] ^ 16'h5A5A, adr[31:16]};
    endfunction

    function automatic req_t mk_req(input logic [31:0] adr, input logic wre, input logic [3:0] sel,
                                    input logic [31:0] dat, input int wait_n);
        req_t r;
        r.adr = adr; r.wre = wre; r.sel = sel; r.dat = dat; r.wait_n = wait_n;
        return r;
    endfunction

    // Reference model: all staged requests are present together at an idle bus; both pending
    // means D wins (fixed) or the port not granted last wins (round-robin). A slave that has not
    // acked by the TOUT-th busy cycle is cut off with zero data and an error.
    task automatic issue_batch();
        int di = 0, ii = 0;
        bit take_d;
        exp_t e;
        req_t r;
        while (di < bd_q.size() || ii < bi_q.size()) begin
            if (di < bd_q.size() && ii < bi_q.size()) begin
`ifdef AEMB2_WBARB_RR_EN
                take_d = !m_last_d;
`else
                take_d = 1'b1;
`endif
            end else begin
                take_d = (di < bd_q.size());
            end
            if (take_d) begin r = bd_q[di]; di++; end
            else begin r = bi_q[ii]; ii++; end
            e.is_d   = take_d;
            e.adr    = r.adr;
            e.wre    = take_d ? r.wre : 1'b0;
            e.sel    = take_d ? r.sel : 4'hF;
            e.wdat   = r.dat;
            e.wait_n = r.wait_n;
            e.err    = (r.wait_n >= TOUT);
            e.rdat   = e.err ? 32'h0 : slave_rd(r.adr);
            e.lat    = e.err ? TOUT : r.wait_n + 1;
            exp_q.push_back(e);
            m_last_d = take_d;
        end
        foreach (bd_q[k]) d_reqq.push_back(bd_q[k]);
        foreach (bi_q[k]) i_reqq.push_back(bi_q[k]);
        bd_q.delete();
        bi_q.delete();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || i_active || d_active || i_reqq.size() != 0 ||
                d_reqq.size() != 0) && n < 600) begin
            @(negedge sys_clk_i);
            n++;
        end
        checks++;
        if (n >= 600) begin
            errors++;
            $display("FAIL drain_%s pending=%0d cycles=%0d limit=600", name, exp_q.size(), n);
            finish_sum();
        end
        repeat (2) @(negedge sys_clk_i);
    endtask

    initial begin : i_master
        req_t r;
        iwb_stb_i = 1'b0;
        iwb_adr_i = '0;
        forever begin
            @(posedge sys_clk_i);
            #1;
            if (i_ack_seen) begin i_ack_seen = 0; i_active = 0; end
            if (!i_active) begin
                if (i_reqq.size() > 0) begin
                    r = i_reqq.pop_front();
                    iwb_stb_i = 1'b1; iwb_adr_i = r.adr; i_active = 1;
                end else begin
                    iwb_stb_i = 1'b0;
                end
            end
        end
    end

    initial begin : d_master
        req_t r;
        dwb_stb_i = 1'b0; dwb_wre_i = 1'b0; dwb_sel_i = '0; dwb_adr_i = '0; dwb_dat_i = '0;
        forever begin
            @(posedge sys_clk_i);
            #1;
            if (d_ack_seen) begin d_ack_seen = 0; d_active = 0; end
            if (!d_active) begin
                if (d_reqq.size() > 0) begin
                    r = d_reqq.pop_front();
                    dwb_stb_i = 1'b1; dwb_wre_i = r.wre; dwb_sel_i = r.sel;
                    dwb_adr_i = r.adr; dwb_dat_i = r.dat; d_active = 1;
                end else begin
                    dwb_stb_i = 1'b0;
                end
            end
        end
    end

    // Slave: checks the request against the scoreboard head and acks after that entry's wait states.
    initial begin : slave
        bit          active = 0;
        int          w = 0;
        int          wait_n = 0;
        logic [31:0] c_adr, c_dat;
        logic [3:0]  c_sel;
        logic        c_wre;
        xwb_ack_i = 1'b0;
        xwb_dat_i = '0;
        forever begin
            @(negedge sys_clk_i);
            if (xwb_stb_o) begin
                if (!active) begin
                    active = 1; w = 0;
                    c_adr = xwb_adr_o; c_dat = xwb_dat_o; c_sel = xwb_sel_o; c_wre = xwb_wre_o;
                    if (exp_q.size() == 0) begin
                        checks++; errors++; wait_n = 0;
                        $display("FAIL unexpected_xwb_cycle adr=%h expected=no_cycle", xwb_adr_o);
                    end else begin
                        check("xwb_adr", xwb_adr_o, exp_q[0].adr);
                        check("xwb_wre", xwb_wre_o, exp_q[0].wre);
                        check("xwb_sel", xwb_sel_o, exp_q[0].sel);
                        if (exp_q[0].wre) check("xwb_wdat", xwb_dat_o, exp_q[0].wdat);
                        wait_n = exp_q[0].wait_n;
                    end
                end else begin
                    check("xwb_stable", (xwb_adr_o == c_adr && xwb_dat_o == c_dat &&
                          xwb_sel_o == c_sel && xwb_wre_o == c_wre) ? 1 : 0, 1);
                end
                check("xwb_cyc_eq_stb", xwb_cyc_o, 1);
                if (w == wait_n) begin
                    xwb_ack_i = 1'b1; xwb_dat_i = slave_rd(c_adr);
                end else begin
                    xwb_ack_i = 1'b0; xwb_dat_i = $urandom;
                end
                w++;
            end else begin
                active = 0;
                xwb_ack_i = 1'b0;
                xwb_dat_i = $urandom;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        bit   prev_stb = 0;
        forever begin
            @(negedge sys_clk_i);
            cyc++;
            if (xwb_stb_o && !prev_stb) rise_cyc = cyc;
            prev_stb = xwb_stb_o;
            if (iwb_ack_o || dwb_ack_o) begin
                check("ack_onehot", {31'b0, iwb_ack_o & dwb_ack_o}, 0);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack iwb_ack=%b dwb_ack=%b expected=none", iwb_ack_o, dwb_ack_o);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_port_is_d", {31'b0, dwb_ack_o}, {31'b0, e.is_d});
                    if (dwb_ack_o) begin
                        check("dwb_dat", dwb_dat_o, e.rdat);
                        check("iwb_dat_hold", iwb_dat_o, m_idat);
                        m_ddat = e.rdat;
                        d_ack_seen = 1;
                    end else begin
                        check("iwb_dat", iwb_dat_o, e.rdat);
                        check("dwb_dat_hold", dwb_dat_o, m_ddat);
                        m_idat = e.rdat;
                        i_ack_seen = 1;
                    end
                    check("bus_err", {31'b0, bus_err_o}, {31'b0, e.err});
                    check("ack_latency", cyc - rise_cyc, e.lat);
                    check("xwb_dropped", {31'b0, xwb_stb_o}, 0);
                end
            end else if (bus_err_o) begin
                checks++; errors++;
                $display("FAIL bus_err_without_ack actual=1 expected=0");
            end
        end
    end

    initial begin : watchdog
        #200000;
        checks++; errors++;
        $display("FAIL watchdog simulation time limit reached");
        finish_sum();
    end

    initial begin : main
        int n;
        int nd, ni;
        sys_rst_i = 1'b1;
        repeat (3) @(negedge sys_clk_i);
        check("rst_xwb_stb", xwb_stb_o, 0);
        check("rst_xwb_cyc", xwb_cyc_o, 0);
        check("rst_xwb_wre", xwb_wre_o, 0);
        check("rst_xwb_sel", xwb_sel_o, 0);
        check("rst_xwb_adr", xwb_adr_o, 0);
        check("rst_xwb_dat", xwb_dat_o, 0);
        check("rst_iwb_ack", iwb_ack_o, 0);
        check("rst_dwb_ack", dwb_ack_o, 0);
        check("rst_iwb_dat", iwb_dat_o, 0);
        check("rst_dwb_dat", dwb_dat_o, 0);
        check("rst_bus_err", bus_err_o, 0);
        sys_rst_i = 1'b0;
        @(negedge sys_clk_i);

        // Zero-wait instruction read, cycle by cycle.
        bi_q.push_back(mk_req(32'h100, 1'b0, 4'hF, 32'h0, 0));
        issue_batch();
        @(negedge sys_clk_i); check("zw_c0_stb", xwb_stb_o, 0);
        @(negedge sys_clk_i); check("zw_c1_stb", xwb_stb_o, 1);
        check("zw_c1_adr", xwb_adr_o, 32'h100);
        @(negedge sys_clk_i); check("zw_c2_ack", iwb_ack_o, 1);
        check("zw_c2_dat", iwb_dat_o, 32'hDEAD_BEEF);
        check("zw_c2_stb", xwb_stb_o, 0);
        @(negedge sys_clk_i); check("zw_c3_ack", iwb_ack_o, 0);
        drain("zero_wait");

        // Data write with three slave wait states.
        bd_q.push_back(mk_req(32'h2000, 1'b1, 4'b0011, 32'h1234_5678, 3));
        issue_batch();
        drain("dwb_write");

        // Simultaneous requests (last grant is D here).
        bd_q.push_back(mk_req(32'h3000, 1'b0, 4'hF, 32'h0, 0));
        bi_q.push_back(mk_req(32'h3100, 1'b0, 4'hF, 32'h0, 1));
        issue_batch();
        drain("simultaneous");

        // Timeout, recovery, and the ack-on-last-cycle / one-past boundaries.
        bi_q.push_back(mk_req(32'h4000, 1'b0, 4'hF, 32'h0, 100));
        issue_batch();
        drain("timeout");
        bd_q.push_back(mk_req(32'h4100, 1'b0, 4'hC, 32'h0, 1));
        issue_batch();
        drain("after_timeout");
        bd_q.push_back(mk_req(32'h4200, 1'b0, 4'hF, 32'h0, TOUT - 1));
        bi_q.push_back(mk_req(32'h4300, 1'b0, 4'hF, 32'h0, TOUT));
        issue_batch();
        drain("tout_boundary");

        // Reset one cycle into BUSY_D; the held request must be re-granted afterwards.
        bd_q.push_back(mk_req(32'h5000, 1'b1, 4'hF, 32'hCAFE_F00D, 2));
        issue_batch();
        n = 0;
        while (!xwb_stb_o && n < 20) begin @(negedge sys_clk_i); n++; end
        check("rst_mid_busy_seen", xwb_stb_o, 1);
        sys_rst_i = 1'b1;
        @(negedge sys_clk_i);
        check("rst_mid_xwb_stb", xwb_stb_o, 0);
        check("rst_mid_xwb_adr", xwb_adr_o, 0);
        check("rst_mid_xwb_sel", xwb_sel_o, 0);
        check("rst_mid_xwb_wre", xwb_wre_o, 0);
        check("rst_mid_dwb_ack", dwb_ack_o, 0);
        sys_rst_i = 1'b0;
        m_idat = '0;
        m_ddat = '0;
        // Last grant resets to I, then the re-grant sets it back to D, as the model already holds.
        drain("reset_regrant");

        // Continuous data-side requests with the instruction side pending.
        for (int k = 0; k < 4; k++) bd_q.push_back(mk_req(32'h6000 + k, 1'b0, 4'hF, 32'h0, 0));
        for (int k = 0; k < 3; k++) bi_q.push_back(mk_req(32'h7000 + k, 1'b0, 4'hF, 32'h0, 0));
        issue_batch();
        drain("continuous");

        // Randomised batches.
        for (int b = 0; b < 25; b++) begin
            nd = $urandom_range(0, 3);
            ni = $urandom_range(0, 3);
            if (nd == 0 && ni == 0) ni = 1;
            for (int k = 0; k < nd; k++)
                bd_q.push_back(mk_req($urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                                      $urandom, $urandom_range(0, TOUT + 1)));
            for (int k = 0; k < ni; k++)
                bi_q.push_back(mk_req($urandom, 1'b0, 4'hF, 32'h0, $urandom_range(0, TOUT + 1)));
            issue_batch();
            drain("random");
        end

        finish_sum();
    end

endmodule
